lpcas_sar_ctrl: RTL and testbench

//  Parametrised successive-approximation ADC sequencer for the LPCAS analog test tile. Drives the
//  on-tile sample switch, capacitive-DAC code and analog input mux, and reads back the comparator.

---
 rtl/lpcas_sar_ctrl_pkg.sv | 20 ++
 rtl/lpcas_sar_ctrl_if.sv | 40 ++++
 rtl/lpcas_sar_ctrl_prio_next.sv | 32 +++
 rtl/lpcas_sar_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lpcas_sar_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpcas_sar_ctrl_pkg.sv
// Shared types and defaults for the LPCAS SAR ADC sequencer.
package lpcas_sar_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NCH        = 4;
    localparam int DEF_SAMPLE_CYC = 4;

    // Channel index width; a single channel still needs one select bit.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpcas_sar_ctrl_if.sv
// Host control/result signals plus the analog-macro side (sample, CDAC, mux, comparator).
interface lpcas_sar_ctrl_if
    import lpcas_sar_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
);
    localparam int CHW = chw_of(NCH);

    // host side
    logic             start;
    logic             abort;
    logic             cont;
    logic [NCH-1:0]   ch_mask;
    logic             rd;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic [CHW-1:0]   result_ch;
    logic             result_valid;
    logic             result_new;
    logic             overrun;
    // analog side
    logic             cmp;
    logic             sample_en;
    logic [WIDTH-1:0] dac_code;
    logic [CHW-1:0]   ch_sel;

    modport slave (
        input  start, abort, cont, ch_mask, rd, cmp,
        output busy, result, result_ch, result_valid, result_new, overrun,
               sample_en, dac_code, ch_sel
    );

    modport master (
        output start, abort, cont, ch_mask, rd, cmp,
        input  busy, result, result_ch, result_valid, result_new, overrun,
               sample_en, dac_code, ch_sel
    );

endinterface

// File: rtl/lpcas_sar_ctrl_prio_next.sv
// Channel-mask priority helper: next set bit strictly above idx_i, and lowest set bit.
module lpcas_sar_ctrl_prio_next #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [CHW-1:0] idx_i,
    output logic [CHW-1:0] nxt_o,
    output logic           nxt_found_o,
    output logic [CHW-1:0] low_o,
    output logic           any_o
);

    // Scan high to low so the last hit written is the lowest qualifying bit.
    always_comb begin
        nxt_o       = '0;
        nxt_found_o = 1'b0;
        low_o       = '0;
        any_o       = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_o = CHW'(i);
                any_o = 1'b1;
                if (i > int'(idx_i)) begin
                    nxt_o       = CHW'(i);
                    nxt_found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lpcas_sar_ctrl.sv
// SAR ADC sequencer: scans a channel mask, samples, runs a binary search on the CDAC
// with the comparator, and posts one result per enabled channel.
module lpcas_sar_ctrl
    import lpcas_sar_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NCH        = DEF_NCH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC
) (
    input logic            clk,
    input logic            rst_n,
    lpcas_sar_ctrl_if.slave bus
);

    localparam int CHW = chw_of(NCH);
    localparam int SW  = $clog2(SAMPLE_CYC + 1);
    localparam int KW  = $clog2(WIDTH);
    localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CYC - 1);
    localparam logic [KW-1:0] KTOP  = KW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic             sample_en_q, sample_en_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic [CHW-1:0]   ch_sel_q, ch_sel_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CHW-1:0]   result_ch_q, result_ch_d;
    logic             result_valid_q, result_valid_d;
    logic             result_new_q, result_new_d;
    logic             overrun_q, overrun_d;

    // Advance looks at the latched mask; start and wrap look at the live mask.
    logic [CHW-1:0] adv_nxt, adv_low, live_nxt, live_low;
    logic           adv_found, adv_any, live_found, live_any;

    lpcas_sar_ctrl_prio_next #(.NCH(NCH), .CHW(CHW)) u_adv (
        .mask_i      (mask_q),
        .idx_i       (ch_sel_q),
        .nxt_o       (adv_nxt),
        .nxt_found_o (adv_found),
        .low_o       (adv_low),
        .any_o       (adv_any)
    );

    lpcas_sar_ctrl_prio_next #(.NCH(NCH), .CHW(CHW)) u_live (
        .mask_i      (bus.ch_mask),
        .idx_i       ('0),
        .nxt_o       (live_nxt),
        .nxt_found_o (live_found),
        .low_o       (live_low),
        .any_o       (live_any)
    );

    logic unused_prio;
    assign unused_prio = ^{adv_low, adv_any, live_nxt, live_found};

    // Next state and next registered outputs; abort overrides everything at the end.
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        code_d         = code_q;
        k_d            = k_q;
        scnt_d         = scnt_q;
        sample_en_d    = sample_en_q;
        dac_code_d     = dac_code_q;
        ch_sel_d       = ch_sel_q;
        result_d       = result_q;
        result_ch_d    = result_ch_q;
        result_valid_d = 1'b0;
        result_new_d   = result_new_q & ~bus.rd;
        overrun_d      = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && live_any) begin
                    mask_d      = bus.ch_mask;
                    ch_sel_d    = live_low;
                    overrun_d   = 1'b0;
                    scnt_d      = '0;
                    code_d      = '0;
                    sample_en_d = 1'b1;
                    dac_code_d  = '0;
                    state_d     = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (scnt_q == SLAST) begin
                    sample_en_d = 1'b0;
                    k_d         = KTOP;
                    dac_code_d  = WIDTH'(1) << KTOP;
                    state_d     = ST_CONVERT;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            ST_CONVERT: begin
                code_d      = code_q;
                code_d[k_q] = bus.cmp;
                if (k_q == '0) begin
                    dac_code_d = '0;
                    state_d    = ST_DONE;
                end else begin
                    k_d        = k_q - KW'(1);
                    dac_code_d = code_d | (WIDTH'(1) << (k_q - KW'(1)));
                end
            end
            ST_DONE: begin
                result_d       = code_q;
                result_ch_d    = ch_sel_q;
                result_valid_d = 1'b1;
                // A read landing on the posting edge consumes the old result, so no overrun.
                result_new_d   = 1'b1;
                if (result_new_q && !bus.rd)
                    overrun_d = 1'b1;
                dac_code_d = '0;
                code_d     = '0;
                scnt_d     = '0;
                if (adv_found) begin
                    ch_sel_d    = adv_nxt;
                    sample_en_d = 1'b1;
                    state_d     = ST_SAMPLE;
                end else if (bus.cont && live_any) begin
                    mask_d      = bus.ch_mask;
                    ch_sel_d    = live_low;
                    sample_en_d = 1'b1;
                    state_d     = ST_SAMPLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d        = ST_IDLE;
            sample_en_d    = 1'b0;
            dac_code_d     = '0;
            mask_d         = mask_q;
            ch_sel_d       = ch_sel_q;
            result_d       = result_q;
            result_ch_d    = result_ch_q;
            result_valid_d = 1'b0;
            result_new_d   = result_new_q & ~bus.rd;
            overrun_d      = overrun_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            code_q         <= '0;
            k_q            <= '0;
            scnt_q         <= '0;
            sample_en_q    <= 1'b0;
            dac_code_q     <= '0;
            ch_sel_q       <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
            result_new_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            code_q         <= code_d;
            k_q            <= k_d;
            scnt_q         <= scnt_d;
            sample_en_q    <= sample_en_d;
            dac_code_q     <= dac_code_d;
            ch_sel_q       <= ch_sel_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_ch_q    <= result_ch_d;
            result_valid_q <= result_valid_d;
            result_new_q   <= result_new_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.sample_en    = sample_en_q;
    assign bus.dac_code     = dac_code_q;
    assign bus.ch_sel       = ch_sel_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_ch    = result_ch_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_new   = result_new_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_lpcas_sar_ctrl.sv
// Directed bench for lpcas_sar_ctrl: default instance plus two parameter-sweep instances.
module tb_lpcas_sar_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default instance
    lpcas_sar_ctrl_if #(.WIDTH(8), .NCH(4)) bus ();
    logic [7:0] vin [4];
    assign bus.cmp = (vin[bus.ch_sel] >= bus.dac_code);
    lpcas_sar_ctrl #(.WIDTH(8), .NCH(4), .SAMPLE_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // WIDTH=4, NCH=1, SAMPLE_CYC=1
    lpcas_sar_ctrl_if #(.WIDTH(4), .NCH(1)) b4 ();
    logic [3:0] vin4 [2];
    assign b4.cmp = (vin4[b4.ch_sel] >= b4.dac_code);
    lpcas_sar_ctrl #(.WIDTH(4), .NCH(1), .SAMPLE_CYC(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // WIDTH=12, NCH=6, SAMPLE_CYC=1
    lpcas_sar_ctrl_if #(.WIDTH(12), .NCH(6)) b12 ();
    logic [11:0] vin12 [8];
    assign b12.cmp = (vin12[b12.ch_sel] >= b12.dac_code);
    lpcas_sar_ctrl #(.WIDTH(12), .NCH(6), .SAMPLE_CYC(1)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then report the edge count to the first result_valid.
    task automatic run_one(input logic [3:0] mask, output int lat, output logic [7:0] res,
                           output logic [1:0] ch, output logic busy_after);
        bus.ch_mask = mask;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1;
        res = '0;
        ch  = '0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.result_valid) begin
                lat = n;
                res = bus.result;
                ch  = bus.result_ch;
                break;
            end
        end
        tick();
        busy_after = bus.busy;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && bus.busy; n++) tick();
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] vin;      // {vin3, vin2, vin1, vin0}
        logic [7:0]  exp_res;
        logic [1:0]  exp_ch;
        int          exp_lat;
        logic        exp_busy; // busy one edge after the first result
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lat;
        logic [7:0] res;
        logic [1:0] ch;
        logic bsy;
        int cnt;
        int tms [4];
        logic [7:0] rs [4];
        logic [1:0] cs [4];
        logic ov [4];
        logic seen_rv, seen_busy;

        tbl[0] = '{4'b0100, 32'h11A5_2233, 8'hA5, 2'd2, 13, 1'b0};
        tbl[1] = '{4'b0001, 32'h1122_3300, 8'h00, 2'd0, 13, 1'b0};
        tbl[2] = '{4'b1000, 32'hFF00_0000, 8'hFF, 2'd3, 13, 1'b0};
        tbl[3] = '{4'b0010, 32'h0000_5A00, 8'h5A, 2'd1, 13, 1'b0};
        tbl[4] = '{4'b0110, 32'h00C3_7E00, 8'h7E, 2'd1, 13, 1'b1};

        bus.start = 0; bus.abort = 0; bus.cont = 0; bus.ch_mask = '0; bus.rd = 0;
        b4.start = 0;  b4.abort = 0;  b4.cont = 0;  b4.ch_mask = '0;  b4.rd = 0;
        b12.start = 0; b12.abort = 0; b12.cont = 0; b12.ch_mask = '0; b12.rd = 0;
        for (int i = 0; i < 4; i++) vin[i] = '0;
        for (int i = 0; i < 2; i++) vin4[i] = '0;
        for (int i = 0; i < 8; i++) vin12[i] = '0;

        // reset state
        tick(); tick();
        chk("reset_outs", {bus.busy, bus.sample_en, bus.result_valid, bus.result_new, bus.overrun}, 0);
        chk("reset_codes", {bus.dac_code, bus.result, bus.ch_sel, bus.result_ch}, 0);
        rst_n = 1'b1;
        tick();

        // test 2 detailed: sample/convert timing on channel 2
        vin[2] = 8'hA5;
        bus.ch_mask = 4'b0100;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t2_sample_ch", {bus.sample_en, bus.busy, 6'd0, bus.ch_sel}, {1'b1, 1'b1, 6'd0, 2'd2});
        chk("t2_sample_dac", bus.dac_code, 8'h00);
        repeat (4) tick();
        chk("t2_first_trial", {bus.sample_en, bus.dac_code}, {1'b0, 8'h80});
        wait_idle();

        // single-channel vectors from the table
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) vin[i] = tbl[v].vin[i*8 +: 8];
            run_one(tbl[v].mask, lat, res, ch, bsy);
            chk($sformatf("tbl%0d_lat", v), lat, tbl[v].exp_lat);
            chk($sformatf("tbl%0d_res", v), res, tbl[v].exp_res);
            chk($sformatf("tbl%0d_ch", v), ch, tbl[v].exp_ch);
            chk($sformatf("tbl%0d_busy", v), bsy, tbl[v].exp_busy);
            wait_idle();
        end

        // test 3: three channels, no reads -> overrun on second result
        bus.rd = 1'b1; tick(); bus.rd = 1'b0;
        vin[0] = 8'h00; vin[1] = 8'hFF; vin[2] = 8'h77; vin[3] = 8'h3C;
        bus.ch_mask = 4'b1011;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ch_mask = 4'b0100;   // mid-scan change must be ignored
        cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.result_valid && cnt < 4) begin
                tms[cnt] = n; rs[cnt] = bus.result; cs[cnt] = bus.result_ch; ov[cnt] = bus.overrun;
                cnt++;
            end
        end
        chk("t3_count", cnt, 3);
        if (cnt >= 3) begin
            chk("t3_r0", {tms[0][7:0], rs[0], 6'd0, cs[0]}, {8'd13, 8'h00, 6'd0, 2'd0});
            chk("t3_r1", {tms[1][7:0], rs[1], 6'd0, cs[1]}, {8'd26, 8'hFF, 6'd0, 2'd1});
            chk("t3_r2", {tms[2][7:0], rs[2], 6'd0, cs[2]}, {8'd39, 8'h3C, 6'd0, 2'd3});
            chk("t3_ov", {ov[0], ov[1], ov[2]}, 3'b011);
        end
        chk("t3_idle", bus.busy, 1'b0);

        // test 4: continuous on channel 0 with reads, then drop cont
        bus.rd = 1'b1; tick(); bus.rd = 1'b0;
        vin[0] = 8'h81;
        bus.cont    = 1'b1;
        bus.ch_mask = 4'b0001;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 80; n++) begin
            tick();
            bus.rd = 1'b0;
            if (bus.result_valid) begin
                if (cnt < 4) begin tms[cnt] = n; rs[cnt] = bus.result; end
                cnt++;
                bus.rd = 1'b1;
                if (cnt == 3) bus.cont = 1'b0;
            end
        end
        bus.rd = 1'b0;
        chk("t4_count", cnt, 4);
        if (cnt == 4) begin
            chk("t4_times", {tms[0][7:0], tms[1][7:0], tms[2][7:0], tms[3][7:0]},
                {8'd13, 8'd26, 8'd39, 8'd52});
            chk("t4_res", {rs[0], rs[3]}, {8'h81, 8'h81});
        end
        chk("t4_ov_busy", {bus.overrun, bus.busy}, 2'b00);

        // rd coinciding with the posting edge: result_new stays, no overrun
        vin[0] = 8'h42;
        run_one(4'b0001, lat, res, ch, bsy);
        chk("rdsame_pre", {bus.result_new, bus.overrun}, 2'b10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk("rdsame_post", {bus.result_valid, bus.result_new, bus.overrun}, 3'b110);
        tick();

        // test 5: abort at k=4 with start held high
        vin[2] = 8'hA5;
        bus.ch_mask = 4'b0100;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        chk("t5_trial_k4", bus.dac_code, 8'hB0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t5_abort_outs", {bus.busy, bus.sample_en, bus.result_valid, bus.dac_code}, 0);
        chk("t5_kept", {bus.result, bus.result_new, bus.overrun}, {8'h42, 1'b1, 1'b0});
        seen_rv = 0; seen_busy = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            seen_rv   |= bus.result_valid;
            seen_busy |= bus.busy;
        end
        chk("t5_quiet", {seen_rv, seen_busy}, 2'b00);
        bus.ch_mask = 4'b0000;
        bus.start   = 1'b1;
        seen_busy = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            seen_busy |= bus.busy;
        end
        bus.start = 1'b0;
        chk("t5_mask0", seen_busy, 1'b0);

        // test 1: async reset mid-CONVERT
        vin[1] = 8'h99;
        bus.ch_mask = 4'b0010;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_outs", {bus.busy, bus.sample_en, bus.result_valid, bus.result_new, bus.overrun}, 0);
        chk("t1_rst_codes", {bus.dac_code, bus.result, bus.ch_sel, bus.result_ch}, 0);
        tick();
        rst_n = 1'b1;
        seen_rv = 0; seen_busy = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            seen_rv   |= bus.result_valid;
            seen_busy |= bus.busy;
        end
        chk("t1_after", {seen_rv, seen_busy}, 2'b00);

        // test 6a: WIDTH=4, NCH=1, SAMPLE_CYC=1 -> latency 6
        for (int v = 0; v < 2; v++) begin
            logic [3:0] want;
            want = (v == 0) ? 4'hB : 4'h3;
            vin4[0] = want;
            b4.ch_mask = 1'b1;
            b4.start   = 1'b1;
            tick();
            b4.start = 1'b0;
            lat = -1;
            for (int n = 1; n <= 30; n++) begin
                tick();
                if (b4.result_valid) begin lat = n; break; end
            end
            chk($sformatf("w4_lat%0d", v), lat, 6);
            chk($sformatf("w4_res%0d", v), {b4.result, 3'd0, b4.result_ch}, {want, 3'd0, 1'b0});
            tick();
            chk($sformatf("w4_idle%0d", v), b4.busy, 1'b0);
        end

        // test 6b: WIDTH=12, NCH=6, SAMPLE_CYC=1 -> latency 14, channels 1 then 5
        vin12[1] = 12'h001;
        vin12[5] = 12'hABC;
        b12.ch_mask = 6'b100010;
        b12.start   = 1'b1;
        tick();
        b12.start = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (b12.result_valid && cnt < 4) begin
                tms[cnt] = n;
                chk($sformatf("w12_res%0d", cnt), {b12.result, 1'b0, b12.result_ch},
                    (cnt == 0) ? {12'h001, 1'b0, 3'd1} : {12'hABC, 1'b0, 3'd5});
                cnt++;
            end
        end
        chk("w12_count", cnt, 2);
        if (cnt == 2) chk("w12_times", {tms[0][7:0], tms[1][7:0]}, {8'd14, 8'd28});
        chk("w12_ov_idle", {b12.overrun, b12.busy}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
